// File: rtl/dp_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// dp_ctrl_fsm
//   Multicycle control FSM for the 16-bit register-file/ALU datapath. It steps
//   through fetch, decode, execute/writeback, load/store and branch/jump. It
//   drives the IR/PC enables, the register-file write, the mux selects and the
//   memory request handshake. The ALU function itself comes from alucontrol,
//   which decodes opcode/opext separately.
//
//   Outputs are decoded from the registered state and the current IR fields.
//   In FETCH, irwrite/pcen must fire in the same cycle that the memory
//   completes. Because of that, mem_ready is combinational into the outputs.
//
// Parameters
//   WIDTH     datapath width (informational only)
//   FLAGBITS  PSR flag count, ordered {N,Z,F,L,C} msb..lsb
//
// Ports
//   clk        clock
//   reset      asynchronous active-low reset
//   opcode     IR[15:12]
//   opext      IR[7:4]
//   cond       IR[11:8], branch/jump condition code
//   flags      current PSR {N,Z,F,L,C}
//   mem_ready  memory completes the current request this cycle
//   mem_req    memory request, held until mem_ready
//   mem_we     write qualifier for mem_req
//   adrsrc     memory address select: 0 = PC, 1 = Rsrc
//   irwrite    load IR
//   pcen       PC write enable
//   pcsrc      PC source: 0 = PC+1, 1 = PC+sext(disp8), 2 = Rsrc
//   regwrite   register-file write
//   memtoreg   writeback select: 1 = memory data
//   alusrcb    ALU B select: 0 = Rsrc, 1 = ext imm8, 2 = imm8<<8 (LUI)
//   signext    imm8 sign-extend (1) / zero-extend (0)
//   flagwrite  PSR update enable
//   illegal    sticky illegal-instruction indicator
//
// Optional feature (macro DP_CTRL_PERF_EN)
//   Defining this macro adds the 32-bit performance counters cyc_cnt and
//   ret_cnt. cyc_cnt counts active cycles. ret_cnt counts retired
//   instructions.
// ---------------------------------------------------------------------------
module dp_ctrl_fsm #(
  parameter int WIDTH    = 16,
  parameter int FLAGBITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          opcode,
  input  logic [3:0]          opext,
  input  logic [3:0]          cond,
  input  logic [FLAGBITS-1:0] flags,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                adrsrc,
  output logic                irwrite,
  output logic                pcen,
  output logic [1:0]          pcsrc,
  output logic                regwrite,
  output logic                memtoreg,
  output logic [1:0]          alusrcb,
  output logic                signext,
  output logic                flagwrite,
  output logic                illegal
`ifdef DP_CTRL_PERF_EN
  ,
  output logic [31:0]         cyc_cnt,
  output logic [31:0]         ret_cnt
`endif
);

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_EXR, S_EXI, S_LD, S_WBL, S_ST, S_BR, S_JMP, S_ILL
  } state_t;

  state_t state_reg, state_next;

  // WIDTH does not affect any control logic. This empty guard only records
  // the datapath width that this controller was written against.
  if (WIDTH < 1) begin : g_width_guard
  end

  // PSR flag positions, {N,Z,F,L,C}
  logic fn, fz, ff, fl, fc;
  assign fn = flags[4];
  assign fz = flags[3];
  assign ff = flags[2];
  assign fl = flags[1];
  assign fc = flags[0];

  logic cond_true;
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'b0000: cond_true = fz;
      4'b0001: cond_true = !fz;
      4'b0010: cond_true = fc;
      4'b0011: cond_true = !fc;
      4'b0100: cond_true = fl;
      4'b0101: cond_true = !fl;
      4'b0110: cond_true = fn;
      4'b0111: cond_true = !fn;
      4'b1000: cond_true = ff;
      4'b1001: cond_true = !ff;
      4'b1010: cond_true = !fl && !fz;
      4'b1011: cond_true = fl || fz;
      4'b1100: cond_true = !fn && !fz;
      4'b1101: cond_true = fn || fz;
      4'b1110: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // ADD/SUB/CMP encodings are the same in opext (register form) and opcode
  // (immediate form). Only these three update the PSR.
  function automatic logic is_arith(input logic [3:0] code);
    return (code == 4'b0101) || (code == 4'b1001) || (code == 4'b1011);
  endfunction

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_RST:   state_next = S_FETCH;
      S_FETCH: if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        state_next = S_ILL;
        case (opcode)
          4'b0000: begin
            case (opext)
              4'b0101, 4'b1001, 4'b1011, 4'b0001,
              4'b0010, 4'b0011, 4'b1101: state_next = S_EXR;
              default:                   state_next = S_ILL;
            endcase
          end
          4'b0101, 4'b1001, 4'b1011, 4'b0001,
          4'b0010, 4'b0011, 4'b1101, 4'b1111: state_next = S_EXI;
          4'b1000: begin
            case (opext)
              4'b0100, 4'b0000, 4'b0001: state_next = S_EXR;
              default:                   state_next = S_ILL;
            endcase
          end
          4'b0100: begin
            case (opext)
              4'b0000: state_next = S_LD;
              4'b0100: state_next = S_ST;
              4'b1100: state_next = S_JMP;
              default: state_next = S_ILL;
            endcase
          end
          4'b1100: state_next = S_BR;
          default: state_next = S_ILL;
        endcase
      end
      S_EXR, S_EXI, S_WBL, S_BR, S_JMP: state_next = S_FETCH;
      S_LD:    if (mem_ready) state_next = S_WBL;
      S_ST:    if (mem_ready) state_next = S_FETCH;
      S_ILL:   state_next = S_ILL;
      default: state_next = S_RST;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_RST;
    else        state_reg <= state_next;
  end

`ifdef DP_CTRL_PERF_EN
  // A retirement is any return to FETCH from an instruction-final state.
  // FETCH->FETCH (waiting) and RST->FETCH do not count as retirements.
  logic retire;
  assign retire = (state_next == S_FETCH) &&
                  ((state_reg == S_EXR) || (state_reg == S_EXI) || (state_reg == S_WBL) ||
                   (state_reg == S_ST)  || (state_reg == S_BR)  || (state_reg == S_JMP));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt <= 32'd0;
      ret_cnt <= 32'd0;
    end else begin
      if ((state_reg != S_RST) && (state_reg != S_ILL)) cyc_cnt <= cyc_cnt + 32'd1;
      if (retire) ret_cnt <= ret_cnt + 32'd1;
    end
  end
`endif

  // Output decode
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    adrsrc    = 1'b0;
    irwrite   = 1'b0;
    pcen      = 1'b0;
    pcsrc     = 2'd0;
    regwrite  = 1'b0;
    memtoreg  = 1'b0;
    alusrcb   = 2'd0;
    signext   = 1'b0;
    flagwrite = 1'b0;
    illegal   = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_req = 1'b1;
        irwrite = mem_ready;
        pcen    = mem_ready;
      end
      S_EXR: begin
        if (opcode == 4'b1000) begin
          // LSH uses the register shift amount. LSHI uses the signed imm8.
          regwrite = 1'b1;
          if (opext != 4'b0100) begin
            alusrcb = 2'd1;
            signext = 1'b1;
          end
        end else begin
          regwrite  = (opext != 4'b1011);
          flagwrite = is_arith(opext);
        end
      end
      S_EXI: begin
        regwrite  = (opcode != 4'b1011);
        flagwrite = is_arith(opcode);
        signext   = is_arith(opcode);
        alusrcb   = (opcode == 4'b1111) ? 2'd2 : 2'd1;
      end
      S_LD: begin
        mem_req = 1'b1;
        adrsrc  = 1'b1;
      end
      S_WBL: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_ST: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adrsrc  = 1'b1;
      end
      S_BR: begin
        pcen  = cond_true;
        pcsrc = cond_true ? 2'd1 : 2'd0;
      end
      S_JMP: begin
        pcen  = cond_true;
        pcsrc = cond_true ? 2'd2 : 2'd0;
      end
      S_ILL:   illegal = 1'b1;
      default: ;
    endcase
  end

endmodule
